// File: rtl/dm_responder_if.sv
// CPU data-port bundle for dm_responder: read enable, word address,
// per-byte active-low write enables, write data and combinational read data.
interface dm_responder_if #(
    parameter int AW = 14
);
    logic          DM_OE;
    logic [AW-1:0] DM_A;
    logic [3:0]    DM_WEB;
    logic [31:0]   DM_DI;
    logic [31:0]   DM_DO;

    modport master (
        output DM_OE, DM_A, DM_WEB, DM_DI,
        input  DM_DO
    );

    modport slave (
        input  DM_OE, DM_A, DM_WEB, DM_DI,
        output DM_DO
    );
endinterface

// File: rtl/dm_responder.sv
// Word-addressed data memory with a zeroing sweep after reset or on request,
// byte-lane writes, combinational reads and saturating access statistics.
//
// state    | meaning
// ST_CLEAR | sweep writes zero to mem[clr_ptr]; reads return 0, writes are dropped
// ST_READY | normal CPU read/write service; clr_req_i starts a new sweep
module dm_responder #(
    parameter int DEPTH = 16384,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    dm_responder_if.slave    dm,
    input  logic             clr_req_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] rd_cnt_o,
    output logic [CNT_W-1:0] wr_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic [31:0]   mem [DEPTH];

    logic in_range;
    logic wr_req;
    logic sweep_last;
    logic rd_inc, wr_inc, drop_inc;

    // Only matters for non-power-of-2 depths; otherwise always true.
    assign in_range   = ({1'b0, dm.DM_A} < (AW+1)'(DEPTH));
    assign wr_req     = (dm.DM_WEB != 4'b1111);
    assign sweep_last = (clr_ptr_q == AW'(DEPTH - 1));

    assign rd_inc   = (state_q == ST_READY) && dm.DM_OE;
    assign wr_inc   = (state_q == ST_READY) && wr_req;
    assign drop_inc = (state_q == ST_CLEAR) && wr_req;

    assign busy_o = (state_q == ST_CLEAR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (sweep_last) begin
                    state_d   = ST_READY;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + AW'(1);
                end
            end
            ST_READY: begin
                if (clr_req_i) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Array has no reset; a write on the edge that requests a clear still lands.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_ptr_q] <= '0;
        end else if (wr_req && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (!dm.DM_WEB[i]) begin
                    mem[dm.DM_A][8*i +: 8] <= dm.DM_DI[8*i +: 8];
                end
            end
        end
    end

    // Read path sees the pre-edge contents, so read-during-write returns old data.
    always_comb begin
        dm.DM_DO = '0;
        if ((state_q == ST_READY) && dm.DM_OE && in_range) begin
            dm.DM_DO = mem[dm.DM_A];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_o   <= '0;
            wr_cnt_o   <= '0;
            drop_cnt_o <= '0;
        end else begin
            if (rd_inc && (rd_cnt_o != '1)) begin
                rd_cnt_o <= rd_cnt_o + CNT_W'(1);
            end
            if (wr_inc && (wr_cnt_o != '1)) begin
                wr_cnt_o <= wr_cnt_o + CNT_W'(1);
            end
            if (drop_inc && (drop_cnt_o != '1)) begin
                drop_cnt_o <= drop_cnt_o + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder at DEPTH=16, CNT_W=4: vector table for
// READY-mode reads/writes plus hand sequences for sweep, clear and reset.
module tb_dm_responder;
    localparam int DEPTH = 16;
    localparam int CNT_W = 4;
    localparam int AW    = $clog2(DEPTH);

    logic             clk;
    logic             rst;
    logic             clr_req_i;
    logic             busy_o;
    logic [CNT_W-1:0] rd_cnt_o;
    logic [CNT_W-1:0] wr_cnt_o;
    logic [CNT_W-1:0] drop_cnt_o;

    int checks;
    int failures;

    dm_responder_if #(.AW(AW)) dm_if ();

    dm_responder #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dm         (dm_if.slave),
        .clr_req_i  (clr_req_i),
        .busy_o     (busy_o),
        .rd_cnt_o   (rd_cnt_o),
        .wr_cnt_o   (wr_cnt_o),
        .drop_cnt_o (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          oe;
        logic [AW-1:0] a;
        logic [3:0]    web;
        logic [31:0]   di;
        logic [31:0]   exp_do;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic oe, input logic [AW-1:0] a, input logic [3:0] web,
                         input logic [31:0] di, input logic clr);
        dm_if.DM_OE  = oe;
        dm_if.DM_A   = a;
        dm_if.DM_WEB = web;
        dm_if.DM_DI  = di;
        clr_req_i    = clr;
    endtask

    task automatic count_sweep(output int n);
        n = 0;
        while (busy_o && n < 100) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        logic do_bad;

        checks   = 0;
        failures = 0;

        vecs[0]  = '{1'b1, 4'd5,  4'b1111, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 4'd5,  4'b0000, 32'hAABBCCDD, 32'h0};
        vecs[2]  = '{1'b1, 4'd5,  4'b1111, 32'h0,        32'hAABBCCDD};
        vecs[3]  = '{1'b0, 4'd5,  4'b1010, 32'h11223344, 32'h0};
        vecs[4]  = '{1'b1, 4'd5,  4'b1111, 32'h0,        32'hAA22CC44};
        vecs[5]  = '{1'b1, 4'd7,  4'b0000, 32'h1,        32'h0};
        vecs[6]  = '{1'b1, 4'd7,  4'b0000, 32'h2,        32'h1};
        vecs[7]  = '{1'b1, 4'd7,  4'b1111, 32'h0,        32'h2};
        vecs[8]  = '{1'b1, 4'd3,  4'b1110, 32'h55,       32'h0};
        vecs[9]  = '{1'b1, 4'd3,  4'b1111, 32'h0,        32'h55};
        vecs[10] = '{1'b0, 4'd3,  4'b1111, 32'h0,        32'h0};
        vecs[11] = '{1'b1, 4'd15, 4'b0111, 32'h12345678, 32'h0};
        vecs[12] = '{1'b1, 4'd15, 4'b1111, 32'h0,        32'h12000000};

        rst = 1'b0;
        drive(1'b1, 4'd3, 4'b1111, 32'h0, 1'b0);
        #2;
        chk("rst_busy", 32'(busy_o), 32'd1);
        chk("rst_do", dm_if.DM_DO, 32'h0);
        chk("rst_rd_cnt", 32'(rd_cnt_o), 32'd0);
        chk("rst_wr_cnt", 32'(wr_cnt_o), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt_o), 32'd0);
        step();
        step();
        chk("rst_hold_busy", 32'(busy_o), 32'd1);

        // Initial sweep with OE=1, A=3: DO must stay 0 throughout.
        rst = 1'b1;
        n = 0;
        do_bad = 1'b0;
        while (busy_o && n < 100) begin
            if (dm_if.DM_DO !== 32'h0) do_bad = 1'b1;
            step();
            n++;
        end
        chk("init_sweep_len", 32'(n), 32'd16);
        chk("init_sweep_do", 32'(do_bad), 32'd0);
        chk("post_sweep_do", dm_if.DM_DO, 32'h0);
        chk("post_sweep_rd_cnt", 32'(rd_cnt_o), 32'd0);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].oe, vecs[i].a, vecs[i].web, vecs[i].di, 1'b0);
            #1;
            chk($sformatf("vec%0d_do", i), dm_if.DM_DO, vecs[i].exp_do);
            step();
        end
        chk("table_rd_cnt", 32'(rd_cnt_o), 32'd10);
        chk("table_wr_cnt", 32'(wr_cnt_o), 32'd6);
        chk("table_drop_cnt", 32'(drop_cnt_o), 32'd0);

        // Clear request with a simultaneous write; then a dropped write and an ignored clr_req mid-sweep.
        drive(1'b0, 4'd2, 4'b0000, 32'hFF, 1'b1);
        #1;
        step();
        drive(1'b0, 4'd2, 4'b1111, 32'h0, 1'b0);
        chk("clr_busy", 32'(busy_o), 32'd1);
        chk("clr_wr_cnt", 32'(wr_cnt_o), 32'd7);
        n = 0;
        while (busy_o && n < 100) begin
            if (n == 5)      drive(1'b0, 4'd1, 4'b0000, 32'hDEADBEEF, 1'b0);
            else if (n == 8) drive(1'b0, 4'd0, 4'b1111, 32'h0, 1'b1);
            else             drive(1'b0, 4'd0, 4'b1111, 32'h0, 1'b0);
            step();
            n++;
        end
        drive(1'b1, 4'd2, 4'b1111, 32'h0, 1'b0);
        #1;
        chk("clr_sweep_len", 32'(n), 32'd16);
        chk("clr_drop_cnt", 32'(drop_cnt_o), 32'd1);
        chk("clr_wr_cnt_after", 32'(wr_cnt_o), 32'd7);
        chk("clr_a2_do", dm_if.DM_DO, 32'h0);
        dm_if.DM_A = 4'd1;
        #1;
        chk("clr_a1_do", dm_if.DM_DO, 32'h0);
        dm_if.DM_A = 4'd5;
        #1;
        chk("clr_a5_do", dm_if.DM_DO, 32'h0);

        // Reset asserted at sweep edge 8.
        drive(1'b0, 4'd0, 4'b1111, 32'h0, 1'b1);
        #1;
        step();
        drive(1'b1, 4'd3, 4'b1111, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) step();
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_o), 32'd1);
        chk("mid_rst_do", dm_if.DM_DO, 32'h0);
        chk("mid_rst_rd_cnt", 32'(rd_cnt_o), 32'd0);
        chk("mid_rst_wr_cnt", 32'(wr_cnt_o), 32'd0);
        chk("mid_rst_drop_cnt", 32'(drop_cnt_o), 32'd0);
        step();
        rst = 1'b1;
        count_sweep(n);
        dm_if.DM_OE = 1'b0;
        chk("mid_rst_sweep_len", 32'(n), 32'd16);
        chk("mid_rst_rd_cnt_after", 32'(rd_cnt_o), 32'd0);
        chk("mid_rst_wr_cnt_after", 32'(wr_cnt_o), 32'd0);
        chk("mid_rst_drop_cnt_after", 32'(drop_cnt_o), 32'd0);

        // Saturation: 20 read+write cycles, then one more read.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 4'd9, 4'b0000, 32'(i), 1'b0);
            step();
        end
        chk("sat_rd_cnt", 32'(rd_cnt_o), 32'hF);
        chk("sat_wr_cnt", 32'(wr_cnt_o), 32'hF);
        drive(1'b1, 4'd9, 4'b1111, 32'h0, 1'b0);
        #1;
        chk("sat_a9_do", dm_if.DM_DO, 32'd19);
        step();
        chk("sat_rd_cnt_hold", 32'(rd_cnt_o), 32'hF);
        chk("sat_busy", 32'(busy_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001: Parameter DEPTH, default 16384, is the number of 32-bit words; the address width is $clog2(DEPTH), which is 14 at the default.
REQ-002: Parameter CNT_W, default 16, is the width of each access counter.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst  input  1  reset, asynchronous, active-low.
REQ-005: DM_OE  input  1  read enable from the CPU data port.
REQ-006: DM_A  input  $clog2(DEPTH)  word address.
REQ-007: DM_WEB  input  4  per-byte write enable, active-low; bit i gates byte lane [8i+7:8i].
REQ-008: DM_DI  input  32  write data.
REQ-009: DM_DO  output  32  read data, combinational (no-delay).
REQ-010: clr_req_i  input  1  single-cycle request to re-zero the whole array.
REQ-011: busy_o  output  1  high while the clear sweep runs.
REQ-012: rd_cnt_o, wr_cnt_o, drop_cnt_o  output  CNT_W each  access statistics.

Function
REQ-013: Two-state FSM, CLEAR and READY, SHALL control the block.
- CLEAR: zero-sweep pointer clr_ptr writes mem[clr_ptr] <= 0 on each edge and then increments.
- CLEAR -> READY on the edge that writes clr_ptr == DEPTH-1; clr_ptr then wraps to 0.
REQ-014: The sweep SHALL take exactly DEPTH rising edges.
REQ-015: busy_o SHALL equal (state == CLEAR).
REQ-016: READY -> CLEAR SHALL happen on an edge where clr_req_i == 1, with clr_ptr set to 0.
- A write presented on that same edge still completes first.
REQ-017: A clr_req_i asserted while in CLEAR SHALL be ignored; the sweep does not restart.
REQ-018: Read: DM_DO SHALL equal mem[DM_A] when state == READY and DM_OE == 1, else 32'h0.
- Combinational, zero-cycle latency.
REQ-019: Write in READY: on the edge, each lane i with DM_WEB[i] == 0 SHALL take DM_DI[8i+7:8i]; lanes with DM_WEB[i] == 1 keep their value.
REQ-020: A write is any DM_WEB != 4'b1111.
REQ-021: Read and write to the same address in the same cycle SHALL return the pre-write contents on DM_DO; the new data is visible from the next cycle.
REQ-022: DM_OE and DM_WEB are independent; simultaneous read and write is legal.
REQ-023: Writes presented in CLEAR SHALL NOT modify the array; each such cycle SHALL increment drop_cnt_o.
REQ-024: Counter updates per edge:
- rd_cnt_o +1 for each READY cycle with DM_OE == 1.
- wr_cnt_o +1 for each READY cycle containing a write.
REQ-025: All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026: Array contents are undefined only until the first sweep completes; software-visible reads during CLEAR return 0 per REQ-018.
REQ-027: An out-of-range DM_A (>= DEPTH, when DEPTH is not a power of 2) SHALL read 0 and ignore writes, and still count as an access.

Reset
REQ-028: While rst == 0, asynchronously:
- state = CLEAR, clr_ptr = 0.
- busy_o = 1, DM_DO = 0.
- All counters = 0.
REQ-029: After rst rises, the sweep SHALL start on the first rising edge.
REQ-030: Reset asserted mid-sweep or mid-operation SHALL abandon the current activity and restart the sweep from address 0.
REQ-031: Array contents are not reset directly; only the sweep zeroes them.

Verification (DEPTH=16, CNT_W=4)
REQ-032: Reset sequence: release rst, drive DM_OE=1, DM_A=3.
- busy_o stays 1 for exactly 16 edges, then drops.
- DM_DO = 0 throughout the sweep and 32'h0 afterwards.
REQ-033: Byte-lane write: in READY, write A=5, DI=32'hAABBCCDD, WEB=4'b0000; then A=5, DI=32'h11223344, WEB=4'b1010.
- Read A=5 returns 32'hAA22CC44.
REQ-034: Read-during-write: A=7 holds 32'h1; write 32'h2 to A=7 with DM_OE=1.
- DM_DO = 32'h1 in that cycle and 32'h2 in the next.
REQ-035: Clear request: pulse clr_req_i with a simultaneous write of 32'hFF to A=2.
- The write lands, then busy_o is high for 16 edges.
- Afterwards A=2 reads 0.
- A write issued during the sweep leaves the array unchanged and increments drop_cnt_o by 1.
REQ-036: Mid-sweep reset: assert rst at sweep edge 8, release.
- busy_o lasts a full 16 edges again.
- All counters read 0.
REQ-037: Saturation: issue 20 READY reads.
- rd_cnt_o = 4'hF and holds at 4'hF.
